// File: rtl/mem_access_pkg.sv
// Shared size codes, store-buffer payload type and lane helpers for the
// data-memory access path.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int unsigned BE_W   = 4;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] din;
    } wb_entry_t;

    function automatic logic [BE_W-1:0] be_of(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: be_of = 4'b0001 << off;
            SIZE_HALF: be_of = off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be_of = 4'b1111;
            default:   be_of = 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = off[0];
            SIZE_WORD: misaligned = (off != 2'b00);
            default:   misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_lane(input logic [1:0] size, input logic [DATA_W-1:0] wdata);
        case (size)
            SIZE_BYTE: store_lane = {24'b0, wdata[7:0]};
            SIZE_HALF: store_lane = {16'b0, wdata[15:0]};
            default:   store_lane = wdata;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] word, input logic [1:0] off,
                                                   input logic [1:0] size, input logic sign);
        logic [DATA_W-1:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SIZE_BYTE: load_ext = {{24{sign & sh[7]}}, sh[7:0]};
            SIZE_HALF: load_ext = {{16{sign & sh[15]}}, sh[15:0]};
            default:   load_ext = word;
        endcase
    endfunction

endpackage

// File: rtl/dm_store_buf.sv
// Store buffer FIFO; every slot's valid bit and word address are exposed so
// the controller can detect load-after-store hazards.
module dm_store_buf
    import mem_access_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [AW-1:0]             push_addr,
    input  wb_entry_t                 push_data,
    input  logic                      pop,
    output logic [AW-1:0]             head_addr,
    output wb_entry_t                 head_data,
    output logic [DEPTH-1:0]          ent_vld,
    output logic [DEPTH-1:0][AW-1:0]  ent_addr,
    output logic                      full,
    output logic                      empty,
    output logic                      last
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    wb_entry_t     data_q [DEPTH];

    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign last      = (count == (PW+1)'(1));
    assign head_addr = ent_addr[rd_ptr];
    assign head_data = data_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (push) begin
                ent_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= push_addr;
            data_q[wr_ptr]   <= push_data;
        end
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage initiator for the data memory: request decode, store buffering,
// load hazard check, fence arbitration and load alignment.
module dm_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned WB_DEPTH = 4,
    parameter int unsigned AW       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_sign,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    input  logic          fence,
    output logic          wb_empty,
    output logic [AW-1:0] dm_addr,
    output logic [3:0]    dm_be,
    output logic [31:0]   dm_din,
    output logic          dm_we,
    input  logic [31:0]   dm_dout
);

    typedef enum logic {ST_RUN, ST_FENCE} state_t;

    state_t                         state;
    logic [AW-1:0]                  req_waddr;
    logic                           misal, hold, hazard;
    logic                           fire, st_acc, ld_acc, err_acc, pop;
    logic                           full, empty, last;
    logic [AW-1:0]                  head_addr;
    wb_entry_t                      head_data, push_data;
    logic [WB_DEPTH-1:0]            ent_vld;
    logic [WB_DEPTH-1:0][AW-1:0]    ent_addr;
    logic                           unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];
    assign req_waddr   = req_addr[AW+1:2];
    assign misal       = misaligned(req_size, req_addr[1:0]);
    assign hold        = !rst_n || fence || (state == ST_FENCE);
    assign push_data   = '{be: be_of(req_size, req_addr[1:0]), din: store_lane(req_size, req_wdata)};

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < WB_DEPTH; i++)
            if (ent_vld[i] && ent_addr[i] == req_waddr)
                hazard = 1'b1;
    end

    // Errors never touch memory so only the fence holds them off; a full
    // buffer blocks loads too, letting the drain keep the port.
    always_comb begin
        req_ready = 1'b0;
        if (!hold) begin
            if (misal)       req_ready = 1'b1;
            else if (req_we) req_ready = !full;
            else             req_ready = !hazard && !full;
        end
    end

    assign fire    = req_valid && req_ready;
    assign st_acc  = fire && req_we && !misal;
    assign ld_acc  = fire && !req_we && !misal;
    assign err_acc = fire && misal;
    assign pop     = rst_n && !empty && !ld_acc;

    assign dm_we    = pop;
    assign dm_addr  = ld_acc ? req_waddr : head_addr;
    assign dm_be    = pop ? head_data.be : '0;
    assign dm_din   = pop ? head_data.din : '0;
    assign wb_empty = !rst_n || empty || (last && pop && !st_acc);

    dm_store_buf #(
        .DEPTH (WB_DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (st_acc),
        .push_addr (req_waddr),
        .push_data (push_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_vld   (ent_vld),
        .ent_addr  (ent_addr),
        .full      (full),
        .empty     (empty),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                ST_RUN:   if (fence) state <= ST_FENCE;
                ST_FENCE: if (!fence && wb_empty) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
            rsp_valid <= ld_acc || err_acc;
            rsp_err   <= err_acc;
            rsp_rdata <= ld_acc ? load_ext(dm_dout, req_addr[1:0], req_size, req_sign) : '0;
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl against a byte-array memory model.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, fence, wb_empty;
    logic [31:0] rsp_rdata;
    logic [11:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_din, dm_dout;
    logic        dm_we;

    always #5 clk = ~clk;

    dm_access_ctrl #(.WB_DEPTH(4), .AW(12)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .fence(fence), .wb_empty(wb_empty), .dm_addr(dm_addr), .dm_be(dm_be), .dm_din(dm_din),
        .dm_we(dm_we), .dm_dout(dm_dout)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    logic [31:0] mem   [4096];
    logic [7:0]  ref_b [16384];
    rsp_t        rsp_q [$];
    logic [47:0] wr_q  [$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    assign dm_dout = mem[dm_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory receives right-justified data and places it on the enabled lanes.
    always @(posedge clk) begin
        if (dm_we) begin
            int lo;
            logic [31:0] sh;
            lo = 4;
            for (int b = 3; b >= 0; b--) if (dm_be[b]) lo = b;
            sh = dm_din << (8 * lo);
            for (int b = 0; b < 4; b++) if (dm_be[b]) mem[dm_addr][8*b +: 8] <= sh[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event absent or unexpected (t=%0t)", nm, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) fail_now("rsp_unexpected");
                else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("rsp_latency", 64'(cyc), 64'(e.cyc + 1));
                end
            end
            if (dm_we) begin
                if (wr_q.size() == 0) fail_now("dm_write_unexpected");
                else chk("dm_write", 64'({dm_addr, dm_be, dm_din}), 64'(wr_q.pop_front()));
            end
        end
    end

    // Program-order reference: stores land in the byte array when accepted.
    task automatic model_accept(input logic we, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd);
        int n;
        logic [13:0] ba;
        rsp_t r;
        n  = 1 << sz;
        ba = a[13:0];
        r.cyc = cyc;
        if (sz == 2'd3 || (ba % n) != 0) begin
            r.data = '0;
            r.err  = 1'b1;
            rsp_q.push_back(r);
        end else if (we) begin
            logic [3:0]  be;
            logic [31:0] din;
            for (int i = 0; i < n; i++) ref_b[ba + 14'(i)] = wd[8*i +: 8];
            be  = 4'(((1 << n) - 1) << ba[1:0]);
            din = (n == 4) ? wd : (wd & ((32'd1 << (8 * n)) - 1));
            wr_q.push_back({ba[13:2], be, din});
        end else begin
            logic [31:0] v;
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[ba + 14'(i)];
            if (sg && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            r.data = v;
            r.err  = 1'b0;
            rsp_q.push_back(r);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, output int waits);
        bit done;
        done  = 0;
        waits = 0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_sign = sg; req_addr = a; req_wdata = wd;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                model_accept(we, sz, sg, a, wd);
                done = 1;
            end else if (++waits > 40) begin
                fail_now("req_ready_timeout");
                done = 1;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic resync_ref();
        for (int w = 0; w < 4096; w++)
            for (int b = 0; b < 4; b++) ref_b[4*w + b] = mem[w][8*b +: 8];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        resync_ref();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_sign = 1'b0;
        req_addr = '0; req_wdata = '0; fence = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_dm_we", 64'(dm_we), 64'd0);
        chk("reset_dm_be", 64'(dm_be), 64'd0);
        @(posedge clk); #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_wb_empty", 64'(wb_empty), 64'd1);
        @(posedge clk); #1;

        // byte store then signed byte load
        do_req(1, 2'b00, 0, 32'h103, 32'h0000_00AB, w);
        do_req(0, 2'b00, 1, 32'h103, 32'h0, w);
        // halfword store, unsigned and signed reloads
        do_req(1, 2'b01, 0, 32'h202, 32'hCAFE_8001, w);
        do_req(0, 2'b01, 0, 32'h202, 32'h0, w);
        do_req(0, 2'b01, 1, 32'h202, 32'h0, w);
        idle(3);

        // five stores to distinct words, drained in order
        for (int i = 0; i < 5; i++) do_req(1, 2'b10, 0, 32'h500 + 32'(4 * i), $urandom, w);
        idle(4);

        // word store followed by a same-word load must stall for one drain
        do_req(1, 2'b10, 0, 32'h40, 32'h1234_5678, w);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_sign = 1'b0; req_addr = 32'h40;
        @(negedge clk);
        chk("hazard_stall_ready", 64'(req_ready), 64'd0);
        chk("hazard_drain_we", 64'(dm_we), 64'd1);
        @(posedge clk); #1;
        do_req(0, 2'b10, 0, 32'h40, 32'h0, w);
        chk("hazard_release_waits", 64'(w), 64'd0);
        idle(2);

        // misaligned/reserved requests answer with an error, no memory access
        do_req(0, 2'b10, 0, 32'h42, 32'h0, w);
        do_req(1, 2'b01, 0, 32'h101, 32'hFFFF, w);
        do_req(1, 2'b11, 0, 32'h100, 32'hFFFF, w);
        @(negedge clk);
        chk("err_wb_empty", 64'(wb_empty), 64'd1);
        @(posedge clk); #1;
        idle(2);

        // fence: stores drain, wb_empty rises with the last write
        for (int i = 0; i < 3; i++) do_req(1, 2'b10, 0, 32'h600 + 32'(4 * i), $urandom, w);
        fence = 1'b1; req_we = 1'b1;
        @(negedge clk);
        chk("fence_ready0", 64'(req_ready), 64'd0);
        chk("fence_last_we", 64'(dm_we), 64'd1);
        chk("fence_wb_empty", 64'(wb_empty), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fence_ready1", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        fence = 1'b0;
        @(negedge clk);
        chk("fence_exit_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("run_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        // reset during the drain of a pending store discards it
        do_req(1, 2'b10, 0, 32'h700, 32'hDEAD_BEEF, w);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_drain_we", 64'(dm_we), 64'd0);
        chk("rst_wb_empty", 64'(wb_empty), 64'd1);
        @(posedge clk); #1;
        wr_q.delete();
        rsp_q.delete();
        resync_ref();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_wb_empty", 64'(wb_empty), 64'd1);
        @(posedge clk); #1;
        do_req(0, 2'b10, 0, 32'h700, 32'h0, w);

        // randomized mix over a few words to provoke hazards
        for (int n = 0; n < 300; n++) begin
            int unsigned r;
            logic [1:0]  sz;
            logic [31:0] a;
            r  = $urandom % 16;
            sz = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
            a  = 32'h300 + 32'($urandom_range(0, 7) * 4);
            if ($urandom % 4 != 0) begin
                if (sz == 2'b01) a = a + 32'($urandom_range(0, 1) * 2);
                else if (sz == 2'b00) a = a + 32'($urandom_range(0, 3));
            end else a = a + 32'($urandom_range(0, 3));
            do_req($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, a, $urandom, w);
            if ($urandom % 4 == 0) idle(1);
        end
        idle(10);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        chk("final_wb_empty", 64'(wb_empty), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
